// File: rtl/fp_pkg.sv
// Shared float32 field widths, special-value constants and the accumulator FSM state type.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;

  localparam logic [FP_WIDTH-1:0] FP_POS_ZERO = 32'h0000_0000;
  localparam logic [EXP_W-1:0]    FP_EXP_ONES = 8'hFF;
  localparam logic [FP_WIDTH-1:0] FP_QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/floating_unit.sv
// Combinational float32 add/subtract (op=1: a - b), round-to-nearest-even, with subnormals.
// NaN inputs and Inf-Inf produce the canonical quiet NaN.
module floating_unit
  import fp_pkg::*;
(
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  input  logic                op,
  output logic [FP_WIDTH-1:0] result
);

  logic                w_sb, w_swap, w_eff_sub, w_rup;
  logic                w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic [FP_WIDTH-1:0] w_b_adj, w_x, w_y, w_norm;
  logic [EXP_W-1:0]    w_x_exp, w_y_exp;
  logic [MAN_W:0]      w_x_sig, w_y_sig;
  logic [9:0]          w_x_e, w_y_e, w_d, w_lz, w_max_sh, w_sh, w_e, w_e_f;
  logic [26:0]         w_mx, w_my0, w_my, w_n;
  logic [27:0]         w_sum;
  logic [24:0]         w_m;
  logic [MAN_W-1:0]    w_frac;
  logic [4:0]          w_pos;

  assign w_sb    = b[FP_WIDTH-1] ^ op;
  assign w_b_adj = {w_sb, b[FP_WIDTH-2:0]};
  assign w_a_nan = (a[MAN_W +: EXP_W] == FP_EXP_ONES) && (a[MAN_W-1:0] != '0);
  assign w_b_nan = (b[MAN_W +: EXP_W] == FP_EXP_ONES) && (b[MAN_W-1:0] != '0);
  assign w_a_inf = (a[MAN_W +: EXP_W] == FP_EXP_ONES) && (a[MAN_W-1:0] == '0);
  assign w_b_inf = (b[MAN_W +: EXP_W] == FP_EXP_ONES) && (b[MAN_W-1:0] == '0);

  // x always carries the larger magnitude, so the aligned difference is never negative.
  assign w_swap    = b[FP_WIDTH-2:0] > a[FP_WIDTH-2:0];
  assign w_x       = w_swap ? w_b_adj : a;
  assign w_y       = w_swap ? a : w_b_adj;
  assign w_x_exp   = w_x[MAN_W +: EXP_W];
  assign w_y_exp   = w_y[MAN_W +: EXP_W];
  assign w_x_sig   = {|w_x_exp, w_x[MAN_W-1:0]};
  assign w_y_sig   = {|w_y_exp, w_y[MAN_W-1:0]};
  assign w_x_e     = (w_x_exp == '0) ? 10'd1 : {2'b00, w_x_exp};
  assign w_y_e     = (w_y_exp == '0) ? 10'd1 : {2'b00, w_y_exp};
  assign w_d       = w_x_e - w_y_e;
  assign w_eff_sub = w_x[FP_WIDTH-1] ^ w_y[FP_WIDTH-1];
  assign w_mx      = {w_x_sig, 3'b000};
  assign w_my0     = {w_y_sig, 3'b000};

  always_comb begin
    if (w_d > 10'd26) begin
      w_my = {26'd0, |w_y_sig};
    end else begin
      w_my = (w_my0 >> w_d) | {26'd0, |(w_my0 & ~({27{1'b1}} << w_d))};
    end
  end

  assign w_sum = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my}) : ({1'b0, w_mx} + {1'b0, w_my});

  // Normalise (left shift floors at exponent 1 to form subnormals), then round to nearest even.
  always_comb begin
    w_pos = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (w_sum[i]) w_pos = 5'(i);
    end
    w_lz     = 10'd26 - {5'd0, w_pos};
    w_max_sh = w_x_e - 10'd1;
    w_sh     = 10'd0;
    if (w_sum[27]) begin
      w_n = {w_sum[27:2], |w_sum[1:0]};
      w_e = w_x_e + 10'd1;
    end else begin
      w_sh = (w_lz < w_max_sh) ? w_lz : w_max_sh;
      w_n  = w_sum[26:0] << w_sh;
      w_e  = w_x_e - w_sh;
    end
    w_rup = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
    w_m   = {1'b0, w_n[26:3]} + {24'd0, w_rup};
    if (w_m[24]) begin
      w_e_f  = w_e + 10'd1;
      w_frac = w_m[23:1];
    end else begin
      w_e_f  = w_m[23] ? w_e : 10'd0;
      w_frac = w_m[22:0];
    end
    if (w_e_f >= 10'd255) w_norm = {w_x[FP_WIDTH-1], FP_EXP_ONES, {MAN_W{1'b0}}};
    else                  w_norm = {w_x[FP_WIDTH-1], w_e_f[EXP_W-1:0], w_frac};
  end

  always_comb begin
    if (w_a_nan || w_b_nan) begin
      result = FP_QNAN;
    end else if (w_a_inf && w_b_inf) begin
      result = (a[FP_WIDTH-1] != w_sb) ? FP_QNAN : {a[FP_WIDTH-1], FP_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_inf) begin
      result = {a[FP_WIDTH-1], FP_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      result = {w_sb, FP_EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_sum == '0) begin
      // Exact cancellation gives +0; only same-sign zeros keep their sign.
      result = {(w_eff_sub ? 1'b0 : w_x[FP_WIDTH-1]), {(FP_WIDTH-1){1'b0}}};
    end else begin
      result = w_norm;
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Float32 accumulator: start/len job, one sample per in_valid/in_ready handshake, result held until out_ready.
// Build macro FP_ACC_SUB_EN enables per-sample subtraction via in_sub.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nan,
  output logic             out_inf,
  output logic             busy,
  output state_t           dbg_state
);

  // Handshakes: a sample transfers on a rising edge where in_valid && in_ready; the result
  // transfers where out_valid && out_ready. Valid never depends on ready.

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_sum;
  logic             w_op;
  logic             w_exp_ones;

`ifdef FP_ACC_SUB_EN
  assign w_op = in_sub;
`else
  logic w_in_sub_unused;
  assign w_in_sub_unused = in_sub;
  assign w_op            = 1'b0;
`endif

  floating_unit u_fu (
    .a      (r_acc),
    .b      (in_data),
    .op     (w_op),
    .result (w_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc <= FP_POS_ZERO;
            r_cnt <= len;
            r_state <= (len != '0) ? S_ACCUM : S_DONE;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == {{(CNT_W-1){1'b0}}, 1'b1}) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == S_ACCUM);
  assign out_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign out_data   = r_acc;
  assign dbg_state  = r_state;
  assign w_exp_ones = (r_acc[MAN_W +: EXP_W] == FP_EXP_ONES);
  assign out_nan    = out_valid && w_exp_ones && (r_acc[MAN_W-1:0] != '0);
  assign out_inf    = out_valid && w_exp_ones && (r_acc[MAN_W-1:0] == '0);

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: driver tasks push expected results, a negedge monitor pops and compares.
module tb_fp_accumulator;
  import fp_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   len = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_nan, out_inf, busy;
  state_t       dbg_state;

  logic [W-1:0] exp_q[$];
  logic [2:0]   exp_flags_q[$];   // {check_data, nan, inf}
  int n_cmp = 0;
  int n_err = 0;

  fp_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nan(out_nan), .out_inf(out_inf), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Monitor: every result handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", out_data);
      end else begin
        logic [W-1:0] e;
        logic [2:0]   f;
        e = exp_q.pop_front();
        f = exp_flags_q.pop_front();
        if (f[2]) check("out_data", out_data, e);
        check("out_nan", {31'd0, out_nan}, {31'd0, f[1]});
        check("out_inf", {31'd0, out_inf}, {31'd0, f[0]});
      end
    end
  end

  task automatic pulse_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_sample(input logic [W-1:0] d, input logic sub);
    int k;
    in_data  = d;
    in_sub   = sub;
    in_valid = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 100);
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      in_data = $urandom;
      in_sub  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL result_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      exp_flags_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic run_job(input logic [7:0] l, input logic [W-1:0] d0, input logic [W-1:0] d1,
                         input logic [W-1:0] d2, input logic [3:0] subs,
                         input logic [W-1:0] exp_d, input logic [2:0] flags);
    logic [W-1:0] s[3];
    s[0] = d0; s[1] = d1; s[2] = d2;
    exp_q.push_back(exp_d);
    exp_flags_q.push_back(flags);
    pulse_start(l);
    for (int i = 0; i < int'(l); i++) send_sample(s[i], subs[i]);
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] sub_exp;
`ifdef FP_ACC_SUB_EN
    sub_exp = 32'hC07F_FFFF;
`else
    sub_exp = 32'h407F_FFFF;
`endif

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    @(posedge clk); #1;

    run_job(8'd2, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0, 4'b0000, 32'h407F_FFFF, 3'b100);
    run_job(8'd2, 32'hBFFF_FFFF, 32'h3FFF_FFFF, 32'h0, 4'b0000, 32'h0000_0000, 3'b100);
    run_job(8'd2, 32'h7F80_0000, 32'h42F6_0000, 32'h0, 4'b0000, 32'h7F80_0000, 3'b101);
    run_job(8'd2, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h0, 4'b0011, sub_exp, 3'b100);
    run_job(8'd3, 32'h3F80_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 32'h0000_0000, 3'b100);
    run_job(8'd2, 32'h3F80_0000, 32'h3380_0001, 32'h0, 4'b0000, 32'h3F80_0001, 3'b100);
    run_job(8'd2, 32'h3F80_0000, 32'h3380_0000, 32'h0, 4'b0000, 32'h3F80_0000, 3'b100);
    run_job(8'd2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h0, 4'b0000, 32'h7F80_0000, 3'b101);
    run_job(8'd2, 32'h7FC0_0000, 32'h3F80_0000, 32'h0, 4'b0000, 32'h0, 3'b010);
    run_job(8'd2, 32'h7F80_0000, 32'hFF80_0000, 32'h0, 4'b0000, 32'h0, 3'b010);

    // len=0: result appears next cycle and holds under back-pressure; stray start/in_valid ignored.
    out_ready = 1'b0;
    pulse_start(8'd0);
    @(negedge clk);
    check("len0_out_valid", {31'd0, out_valid}, 32'd1);
    check("len0_out_data", out_data, 32'h0);
    start    = 1'b1;
    len      = 8'd5;
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    repeat (5) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data", out_data, 32'h0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back(32'h0);
    exp_flags_q.push_back(3'b100);
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("after_done_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // Reset mid-job discards the partial accumulation.
    pulse_start(8'd4);
    send_sample(32'h3F80_0000, 1'b0);
    send_sample(32'h4000_0000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    run_job(8'd1, 32'h0000_02CA, 32'h0, 32'h0, 4'b0000, 32'h0000_02CA, 3'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
